instr_loader: RTL and testbench

Upstream stage of the fetch/decode/execute pipeline. Consumes the byte stream delivered by the UART receiver, assembles every four bytes (LSB first) into one 32-bit instruction and writes it into instruction memory at consecutive word addresses. Loading ends on the halt word 0xFFFFFFFF or when memory is full. `load_done_o` then releases the fetch stage.

---
 rtl/instr_loader.sv | 125 ++++++++++++
 tb/tb_instr_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Packs the UART byte stream, LSB first, into 32-bit words and writes them to instruction memory until the halt word or a full memory.
// The write strobe comes one cycle after the 4th byte; there is no backpressure. `LOADER_TIMEOUT_EN adds a partial-word idle timeout.
module instr_loader #(
  parameter int                 N_DATA         = 8,
  parameter int                 NB_DATA        = 32,
  parameter int                 NB_ADDR        = 7,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFFFFFF,
  parameter int                 TIMEOUT_CYCLES = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_DATA-1:0]  rx_data_i,
  input  logic               rx_done_i,
  output logic               mem_wr_en_o,
  output logic [NB_ADDR-1:0] mem_addr_o,
  output logic [NB_DATA-1:0] mem_data_o,
  output logic [NB_ADDR:0]   word_count_o,
  output logic               load_done_o,
  output logic               error_o
);

  localparam int LANES = NB_DATA / N_DATA;

  if (NB_DATA != 4 * N_DATA || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("instr_loader: NB_DATA must be 4*N_DATA and TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [1:0] {ST_RECV, ST_WRITE, ST_DONE} state_t;

  state_t                      state;
  state_t                      state_n;
  logic [1:0]                  byte_cnt;
  // Lanes 0..2 only; the top lane goes straight into mem_data_o with the 4th byte.
  logic [NB_DATA-N_DATA-1:0]   shift_q;
  logic [NB_ADDR-1:0]          wr_ptr;
  logic                        last_byte;
  logic                        tmo_fire;

  assign last_byte = (state == ST_RECV) && rx_done_i && (byte_cnt == 2'd3);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || rx_done_i || state != ST_RECV || byte_cnt == 2'd0) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_fire = (state == ST_RECV) && (byte_cnt != 2'd0) && !rx_done_i &&
                    (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RECV;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    mem_wr_en_o = 1'b0;
    load_done_o = 1'b0;
    case (state)
      ST_RECV: begin
        if (last_byte) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr_en_o = 1'b1;
        if (mem_data_o == HALT_WORD || mem_addr_o == {NB_ADDR{1'b1}}) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_RECV;
        end
      end
      ST_DONE: begin
        load_done_o = 1'b1;
      end
      default: state_n = ST_RECV;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt     <= 2'd0;
      shift_q      <= '0;
      wr_ptr       <= '0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      word_count_o <= '0;
      error_o      <= 1'b0;
    end else begin
      // A byte arriving in the write cycle lands in lane 0 (byte_cnt is 0 there).
      if (rx_done_i && state != ST_DONE) begin
        if (byte_cnt == 2'd3) begin
          mem_data_o <= {rx_data_i, shift_q};
          mem_addr_o <= wr_ptr;
          byte_cnt   <= 2'd0;
        end else begin
          for (int i = 0; i < LANES - 1; i++) begin
            if (byte_cnt == 2'(i)) shift_q[i*N_DATA +: N_DATA] <= rx_data_i;
          end
          byte_cnt <= byte_cnt + 2'd1;
        end
      end else if (tmo_fire) begin
        byte_cnt <= 2'd0;
        error_o  <= 1'b1;
      end

      if (state == ST_WRITE) begin
        wr_ptr       <= wr_ptr + 1'b1;
        word_count_o <= word_count_o + 1'b1;
        if (mem_data_o != HALT_WORD && mem_addr_o == {NB_ADDR{1'b1}}) error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: vector table, directed corner sequences, and random traffic against a byte-level model.
module tb_instr_loader;

`ifdef LOADER_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 50000;
`endif
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        mem_wr_en_o;
  logic [6:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic [7:0]  word_count_o;
  logic        load_done_o;
  logic        error_o;

  instr_loader #(.N_DATA(8), .NB_DATA(32), .NB_ADDR(7), .HALT_WORD(HALT), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .word_count_o(word_count_o), .load_done_o(load_done_o), .error_o(error_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes are collected into words; a write is due in the cycle after the 4th byte.
  int          m_nb, m_cnt, m_idle;
  logic [31:0] m_word;
  bit          m_due, m_done, m_err;
  logic [6:0]  m_addr;
  logic [31:0] m_data;

  logic [6:0]  obs_a[$];
  logic [31:0] obs_d[$];

  typedef struct {
    logic rst; logic rx; logic [7:0] b;
    logic wr; logic [6:0] a; logic [31:0] d; logic [7:0] cnt; logic done; logic err;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic d, input logic [7:0] b);
    bit was_done;
    if (r) begin
      m_nb = 0; m_cnt = 0; m_idle = 0; m_word = '0; m_due = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_data = '0;
      return;
    end
    was_done = m_done;
    if (m_due) begin
      m_cnt++;
      if (m_data == HALT) m_done = 1;
      else if (m_addr == 7'd127) begin m_done = 1; m_err = 1; end
      m_due = 0;
    end
    if (!was_done && d) begin
      m_idle = 0;
      m_word[8*m_nb +: 8] = b;
      m_nb++;
      if (m_nb == 4) begin
        m_due = 1; m_addr = 7'(m_cnt); m_data = m_word; m_nb = 0;
      end
    end
`ifdef LOADER_TIMEOUT_EN
    else if (!was_done && m_nb != 0) begin
      m_idle++;
      if (m_idle == TO) begin m_nb = 0; m_idle = 0; m_err = 1; end
    end
`endif
  endtask

  task automatic model_check();
    logic [63:0] act, exp;
    act = {14'd0, mem_wr_en_o, mem_addr_o, mem_data_o, word_count_o, load_done_o, error_o};
    exp = {14'd0, m_due, m_addr, m_data, 8'(m_cnt), m_done, m_err};
    check("model_cycle", act, exp);
  endtask

  task automatic cyc(input logic r, input logic d, input logic [7:0] b);
    reset = r; rx_done_i = d; rx_data_i = b;
    @(posedge clock);
    #1;
    model_edge(r, d, b);
    if (mem_wr_en_o) begin
      obs_a.push_back(mem_addr_o);
      obs_d.push_back(mem_data_o);
    end
    model_check();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, w[8*k +: 8]);
  endtask

  task automatic restart();
    cyc(1'b1, 1'b0, 8'h00);
    obs_a.delete();
    obs_d.delete();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 32'h00000000, 8'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 1'b0, 7'd0, 32'h00000000, 8'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 7'd0, 32'h00000000, 8'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h01, 1'b0, 7'd0, 32'h00000000, 8'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h20, 1'b1, 7'd0, 32'h20010001, 8'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 32'h20010001, 8'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 7'd0, 32'h20010001, 8'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 7'd0, 32'h20010001, 8'd1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 7'd0, 32'h20010001, 8'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 7'd1, 32'hFFFFFFFF, 8'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 7'd1, 32'hFFFFFFFF, 8'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'hAA, 1'b0, 7'd1, 32'hFFFFFFFF, 8'd2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'hBB, 1'b0, 7'd1, 32'hFFFFFFFF, 8'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'hCC, 1'b0, 7'd1, 32'hFFFFFFFF, 8'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'hDD, 1'b0, 7'd1, 32'hFFFFFFFF, 8'd2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 7'd1, 32'hFFFFFFFF, 8'd2, 1'b1, 1'b0};

    restart();

    // Basic word followed by halt, then ignored bytes.
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].rx, tbl[i].b);
      check($sformatf("tbl_row%0d", i),
            {14'd0, mem_wr_en_o, mem_addr_o, mem_data_o, word_count_o, load_done_o, error_o},
            {14'd0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].cnt, tbl[i].done, tbl[i].err});
    end

    // Byte in the write cycle becomes byte 0 of the next word.
    restart();
    send_word(32'h04030201);
    cyc(1'b0, 1'b1, 8'h05);
    cyc(1'b0, 1'b1, 8'h06);
    cyc(1'b0, 1'b1, 8'h07);
    cyc(1'b0, 1'b1, 8'h08);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("b2b_nwrites", 64'(obs_a.size()), 64'd2);
    if (obs_a.size() == 2) begin
      check("b2b_data0", 64'(obs_d[0]), 64'h04030201);
      check("b2b_addr1", 64'(obs_a[1]), 64'd1);
      check("b2b_data1", 64'(obs_d[1]), 64'h08070605);
    end

    // Reset mid-word discards the partial bytes.
    restart();
    cyc(1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b1, 8'hBB);
    cyc(1'b1, 1'b0, 8'h00);
    send_word(32'h44332211);
    cyc(1'b0, 1'b0, 8'h00);
    check("rst_nwrites", 64'(obs_a.size()), 64'd1);
    if (obs_a.size() == 1) begin
      check("rst_addr", 64'(obs_a[0]), 64'd0);
      check("rst_data", 64'(obs_d[0]), 64'h44332211);
    end

    // Overflow: 128 non-halt words fill memory.
    restart();
    for (int w = 0; w < 128; w++) begin
      send_word({8'(w), 8'h5A, 8'(w * 3), 8'h01});
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc(1'b0, 1'b0, 8'h00);
    end
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovf_nwrites", 64'(obs_a.size()), 64'd128);
    check("ovf_last_addr", 64'(mem_addr_o), 64'd127);
    check("ovf_error", 64'(error_o), 64'd1);
    check("ovf_done", 64'(load_done_o), 64'd1);
    check("ovf_count", 64'(word_count_o), 64'd128);
    send_word(32'h01020304);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovf_no_more_writes", 64'(obs_a.size()), 64'd128);

`ifdef LOADER_TIMEOUT_EN
    // Idle partial word times out; loading continues at the same address.
    restart();
    cyc(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 8'h00);
    check("tmo_error", 64'(error_o), 64'd1);
    check("tmo_nowrite", 64'(obs_a.size()), 64'd0);
    send_word(32'h04030201);
    cyc(1'b0, 1'b0, 8'h00);
    check("tmo_nwrites", 64'(obs_a.size()), 64'd1);
    if (obs_a.size() == 1) begin
      check("tmo_addr", 64'(obs_a[0]), 64'd0);
      check("tmo_data", 64'(obs_d[0]), 64'h04030201);
    end
`endif

    // Random traffic: dense 0xFF bytes so halt words occur; occasional resets.
    restart();
    for (int i = 0; i < 4000; i++) begin
      logic r, d;
      logic [7:0] b;
      r = m_done ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 599) == 0);
      d = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      cyc(r, d, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
